// File: rtl/imem_access_arbiter_pkg.sv
// Shared constants for the instruction-memory arbiter: owner tags and the NOP returned on
// out-of-range fetches.
package imem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_F    = 2'd1,
    TAG_L    = 2'd2
  } tag_e;

  localparam int STREAK_W          = 4;
  localparam int MAX_BURST_DEFAULT = 4;

  localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI  = 3'b000;

  // ADDI x0, x0, 0 -- the canonical NOP.
  localparam logic [31:0] OOR_FETCH_DATA_DEFAULT = {12'd0, 5'd0, FUNCT3_ADDI, 5'd0, OPCODE_ITYPE};

endpackage

// File: rtl/imem_access_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
// slave = arbiter view, master = requesters plus memory array view.
interface imem_access_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_ready;
  logic              f_rvalid;
  logic [31:0]       f_rdata;

  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic [3:0]        l_wstrb;
  logic              l_ready;
  logic              l_rvalid;
  logic [31:0]       l_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_wstrb, mem_rdata,
    output f_ready, f_rvalid, f_rdata, l_ready, l_rvalid, l_rdata,
           mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_wstrb, mem_rdata,
    input  f_ready, f_rvalid, f_rdata, l_ready, l_rvalid, l_rdata,
           mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_access_arbiter_starve_guard.sv
// Counts consecutive loader grants while fetch waits; forces a fetch grant once the streak
// reaches MAX_BURST. Registered streak, combinational force output.
module imem_arb_starve_guard
  import imem_access_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic f_req_i,
  input  logic f_grant_i,
  input  logic l_grant_i,
  output logic force_f_o
);

  localparam logic [STREAK_W-1:0] MAX_B = STREAK_W'(MAX_BURST);

  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (!f_req_i || f_grant_i) begin
      streak_d = '0;
    end else if (l_grant_i && (streak_q != MAX_B)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_f_o = (streak_q == MAX_B);

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares one word-organised instruction memory between fetch (F) and loader (L); L has priority
// with a starvation guard, read data returns 1 cycle after grant. Optional IMEM_ARB_PERF_EN adds counters.
module imem_access_arbiter
  import imem_access_arbiter_pkg::*;
#(
  parameter int          ADDR_W         = 10,
  parameter int          MAX_BURST      = MAX_BURST_DEFAULT,
  parameter logic [31:0] OOR_FETCH_DATA = OOR_FETCH_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_access_arbiter_if.slave  bus
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]           f_stall_cnt,
  output logic [31:0]           l_wr_cnt
`endif
);

  logic f_oor, l_oor;
  logic f_grant, l_grant;
  logic force_f;
  tag_e tag_q, tag_d;
  logic oor_q, oor_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;
  logic unused_addr_bits;

  assign f_oor = |bus.f_addr[31:ADDR_W+2];
  assign l_oor = |bus.l_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^{bus.f_addr[1:0], bus.l_addr[1:0]};

  imem_arb_starve_guard #(.MAX_BURST(MAX_BURST)) u_guard (
    .clk       (clk),
    .reset     (reset),
    .f_req_i   (bus.f_req),
    .f_grant_i (f_grant),
    .l_grant_i (l_grant),
    .force_f_o (force_f)
  );

  // No grants while reset is held.
  assign l_grant = bus.l_req & ~reset & ~(bus.f_req & force_f);
  assign f_grant = bus.f_req & ~reset & ~l_grant;

  assign bus.f_ready = f_grant;
  assign bus.l_ready = l_grant;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wstrb = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    tag_d         = TAG_NONE;
    oor_d         = 1'b0;
    if (l_grant) begin
      bus.mem_en    = ~l_oor;
      bus.mem_we    = bus.l_we;
      bus.mem_wstrb = bus.l_we ? bus.l_wstrb : 4'b0000;
      bus.mem_addr  = bus.l_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.l_wdata;
      tag_d         = bus.l_we ? TAG_NONE : TAG_L;
      oor_d         = l_oor;
    end else if (f_grant) begin
      bus.mem_en    = ~f_oor;
      bus.mem_addr  = bus.f_addr[ADDR_W+1:2];
      tag_d         = TAG_F;
      oor_d         = f_oor;
    end
  end

  // Gating by reset discards a response that would land in the reset cycle.
  assign bus.f_rvalid = (tag_q == TAG_F) & ~reset;
  assign bus.l_rvalid = (tag_q == TAG_L) & ~reset;

  always_comb begin
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;
    if (bus.f_rvalid) f_rdata_d = oor_q ? OOR_FETCH_DATA : bus.mem_rdata;
    if (bus.l_rvalid) l_rdata_d = oor_q ? 32'd0 : bus.mem_rdata;
  end

  assign bus.f_rdata = f_rdata_d;
  assign bus.l_rdata = l_rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q     <= TAG_NONE;
      oor_q     <= 1'b0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      tag_q     <= tag_d;
      oor_q     <= oor_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] f_stall_cnt_q, f_stall_cnt_d;
  logic [31:0] l_wr_cnt_q, l_wr_cnt_d;

  always_comb begin
    f_stall_cnt_d = f_stall_cnt_q;
    l_wr_cnt_d    = l_wr_cnt_q;
    if (bus.f_req && !f_grant && (f_stall_cnt_q != 32'hFFFF_FFFF))
      f_stall_cnt_d = f_stall_cnt_q + 32'd1;
    if (l_grant && bus.l_we && !l_oor && (l_wr_cnt_q != 32'hFFFF_FFFF))
      l_wr_cnt_d = l_wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_stall_cnt_q <= '0;
      l_wr_cnt_q    <= '0;
    end else begin
      f_stall_cnt_q <= f_stall_cnt_d;
      l_wr_cnt_q    <= l_wr_cnt_d;
    end
  end

  assign f_stall_cnt = f_stall_cnt_q;
  assign l_wr_cnt    = l_wr_cnt_q;
`else
  // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed-vector bench for imem_access_arbiter with a behavioural write-first memory array.
module tb_imem_access_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  imem_access_arbiter_if #(.ADDR_W(10)) bus ();

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] f_stall_cnt;
  logic [31:0] l_wr_cnt;
`endif

  imem_access_arbiter #(.ADDR_W(10), .MAX_BURST(4), .OOR_FETCH_DATA(32'h0000_0013)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IMEM_ARB_PERF_EN
    ,
    .f_stall_cnt (f_stall_cnt),
    .l_wr_cnt    (l_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [1024];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) mem_arr[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem_arr[bus.mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
    bus.l_wstrb = '0;
  endtask

  initial begin
    mem_arr[0]    = 32'h55AA_55AA;
    mem_arr[2]    = 32'h0180_0113;
    mem_arr[9'hB0] = 32'hAABB_CCDD;
    bus.mem_rdata = '0;
    idle_inputs();
    reset = 1'b1;

    // Reset held with both requesting: no grants, memory idle.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.f_req = 1'b1; bus.l_req = 1'b1; bus.f_addr = 32'h8;
      #1;
      chk("rst_f_ready", bus.f_ready, 0);
      chk("rst_l_ready", bus.l_ready, 0);
      chk("rst_mem_en",  bus.mem_en,  0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_f_rvalid", bus.f_rvalid, 0);
    chk("rst_l_rvalid", bus.l_rvalid, 0);
    chk("rst_f_rdata",  bus.f_rdata,  0);
    chk("rst_l_rdata",  bus.l_rdata,  0);
    chk("rst_streak",   u_dut.u_guard.streak_q, 0);

    // Plain fetch of word 2.
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h0000_0008;
    #1;
    chk("f1_ready",    bus.f_ready,  1);
    chk("f1_mem_en",   bus.mem_en,   1);
    chk("f1_mem_addr", bus.mem_addr, 2);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("f1_rvalid", bus.f_rvalid, 1);
    chk("f1_rdata",  bus.f_rdata,  32'h0180_0113);

    // Byte-lane write then read-back of the same word.
    @(negedge clk);
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h0000_02C0;
    bus.l_wdata = 32'h0BBF_FB11; bus.l_wstrb = 4'b0001;
    #1;
    chk("lw_ready",    bus.l_ready,   1);
    chk("lw_mem_we",   bus.mem_we,    1);
    chk("lw_wstrb",    bus.mem_wstrb, 4'b0001);
    chk("lw_mem_addr", bus.mem_addr,  32'h0B0);
    @(negedge clk);
    bus.l_we = 1'b0;
    #1;
    chk("lr_ready",   bus.l_ready,   1);
    chk("lr_mem_we",  bus.mem_we,    0);
    chk("lr_wstrb",   bus.mem_wstrb, 0);
    chk("lw_no_rvld", bus.l_rvalid,  0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("lr_rvalid", bus.l_rvalid, 1);
    chk("lr_rdata",  bus.l_rdata,  32'hAABB_CC11);
    chk("lr_f_quiet", bus.f_rvalid, 0);
    @(negedge clk);
    #1;
    chk("lr_hold_vld",  bus.l_rvalid, 0);
    chk("lr_hold_data", bus.l_rdata,  32'hAABB_CC11);

    // Both requesting for 10 cycles: LLLLF LLLLF.
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h2C0;
      end
      #1;
      if (k > 1) begin
        chk($sformatf("burst_f_rvalid_%0d", k - 1), bus.f_rvalid, ((k - 1) % 5 == 0) ? 1 : 0);
        chk($sformatf("burst_l_rvalid_%0d", k - 1), bus.l_rvalid, ((k - 1) % 5 == 0) ? 0 : 1);
      end
      chk($sformatf("burst_f_ready_%0d", k), bus.f_ready, (k % 5 == 0) ? 1 : 0);
      chk($sformatf("burst_l_ready_%0d", k), bus.l_ready, (k % 5 == 0) ? 0 : 1);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("burst_f_rvalid_10", bus.f_rvalid, 1);
    chk("burst_f_rdata",     bus.f_rdata,  32'h0180_0113);
`ifdef IMEM_ARB_PERF_EN
    chk("perf_f_stall", f_stall_cnt, 8);
`endif

    // Out-of-range fetch, then out-of-range loader write and read.
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h0000_1000;
    #1;
    chk("oor_f_ready",  bus.f_ready, 1);
    chk("oor_f_mem_en", bus.mem_en,  0);
    @(negedge clk);
    idle_inputs();
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h0000_1000;
    bus.l_wdata = 32'hDEAD_BEEF; bus.l_wstrb = 4'hF;
    #1;
    chk("oor_f_rvalid", bus.f_rvalid, 1);
    chk("oor_f_rdata",  bus.f_rdata,  32'h0000_0013);
    chk("oor_lw_ready", bus.l_ready,  1);
    chk("oor_lw_en",    bus.mem_en,   0);
    @(negedge clk);
    bus.l_we = 1'b0;
    #1;
    chk("oor_lr_ready",  bus.l_ready,  1);
    chk("oor_lr_en",     bus.mem_en,   0);
    chk("oor_lw_norvld", bus.l_rvalid, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("oor_lr_rvalid", bus.l_rvalid, 1);
    chk("oor_lr_rdata",  bus.l_rdata,  0);
    chk("oor_word0",     mem_arr[0],   32'h55AA_55AA);
`ifdef IMEM_ARB_PERF_EN
    chk("perf_l_wr", l_wr_cnt, 1);
`endif

    // Reset in the cycle after an accepted fetch discards the response.
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h8;
    #1;
    chk("rf_ready", bus.f_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    bus.f_req = 1'b0;
    #1;
    chk("rf_rvalid_in_rst", bus.f_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rf_rvalid_after", bus.f_rvalid, 0);

    // Reset in the middle of a loader streak restarts the streak from zero.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_addr = 32'h2C0;
      #1;
      chk($sformatf("rs_l_ready_%0d", k), bus.l_ready, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rs_f_ready_rst", bus.f_ready, 0);
    chk("rs_l_ready_rst", bus.l_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rs_streak", u_dut.u_guard.streak_q, 0);
    chk("rs_f_ready_1", bus.f_ready, 0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rs_f_ready_%0d", k), bus.f_ready, (k == 5) ? 1 : 0);
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares one single-port, word-organised instruction memory between two requesters: the core fetch port (F) and a program-loader/debug port (L).
- L can write (program load) and read back (verify). F is read-only.
- Sits between the PC/fetch stage and the InstructionMemory storage array.
- Fixed priority to L, with a starvation guard that guarantees F progress during long loads.

Parameters:
- ADDR_W, 10, word-address width of the memory (1024 words).
- MAX_BURST, 4, maximum consecutive L grants while F is waiting; range 1..15.
- OOR_FETCH_DATA, 32'h0000_0013, data returned for out-of-range fetches (ADDI x0,x0,0 = NOP).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request.
- f_addr  in  32  fetch byte address.
- f_ready  out  1  fetch accepted this cycle.
- f_rvalid  out  1  fetch data valid.
- f_rdata  out  32  fetch data.
- l_req  in  1  loader request.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  write data.
- l_wstrb  in  4  byte-lane enables for writes.
- l_ready  out  1  loader accepted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  32  loader read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write.
- mem_wstrb  out  4  memory byte enables.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid 1 cycle after mem_en & ~mem_we.

Behaviour:
- Address decode:
  - Word address is addr[ADDR_W+1:2]; addr[1:0] is ignored (forced word alignment).
  - An address is out of range (OOR) when addr[31:ADDR_W+2] != 0.
- Grant (combinational on current inputs and registered state):
  - Only L requesting -> L granted.
  - Only F requesting -> F granted.
  - Both requesting -> L granted unless streak == MAX_BURST; in that case F is granted.
  - Neither requesting -> no grant.
- Handshake:
  - ready is asserted in the same cycle as the grant; that request is consumed on that clock edge.
  - A requester must hold req and its payload stable until ready is seen.
  - One access per cycle; full throughput with no bubbles.
- Memory drive:
  - mem_en = grant & ~OOR; mem_we = L granted & l_we.
  - For writes: mem_wstrb = l_wstrb, otherwise 4'b0000.
  - mem_addr and mem_wdata come from the granted port; all mem_* outputs are 0 when idle.
- streak counter (4-bit):
  - Increments on each L grant while f_req = 1.
  - Cleared on an F grant or whenever f_req = 0.
  - Saturates at MAX_BURST.
- Response pipeline (registered owner/kind tag, latency 1):
  - F read -> f_rvalid = 1 next cycle; f_rdata = mem_rdata, or OOR_FETCH_DATA if OOR.
  - L read -> l_rvalid = 1 next cycle; l_rdata = mem_rdata, or 0 if OOR.
  - L write -> no rvalid. An OOR write is dropped silently but still acknowledged with l_ready.
  - rdata outputs hold their last value when rvalid = 0.
- Reset values:
  - f_rvalid = 0, l_rvalid = 0, f_rdata = 0, l_rdata = 0, streak = 0, tag = none.
  - ready and mem_* outputs are 0 while reset = 1; no grants are issued during reset.
- Reset mid-operation: an in-flight response is discarded (no rvalid the cycle after reset).
- Same-address cases:
  - An L write followed by an F read of the same word on the next cycle returns the new data.
  - This relies on memory write-first-cycle completion; the arbiter adds no bypass.

Optional Feature:
- Macro: IMEM_ARB_PERF_EN.
- Defined:
  - Adds out port f_stall_cnt [31:0], incremented each cycle with f_req & ~f_ready.
  - Adds out port l_wr_cnt [31:0], incremented on each accepted in-range L write.
  - Both reset to 0, both saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package/header imem_arb.vh:
  - Owner tag encoding: TAG_NONE = 2'd0, TAG_F = 2'd1, TAG_L = 2'd2.
  - Default OOR_FETCH_DATA, reusing the ADDI/OPCODE_ITYPE header constants.
- One natural sub-module: imem_arb_starve_guard (streak counter plus the force-F decision).
- Address decode and response routing stay in the top module.

Test Plan:
- Reset, then f_req = 1 with f_addr = 0x0000_0008 and mem word 2 = 0x0180_0113 -> f_ready same cycle; next cycle f_rvalid = 1, f_rdata = 0x0180_0113.
- l_req = 1 write to 0x0000_02C0, wdata = 0x0BBF_FB11, wstrb = 4'b0001; next cycle L read of the same address -> mem_wstrb = 0001 on the write cycle; l_rvalid with the updated low byte.
- f_req and l_req both held high for 10 cycles, MAX_BURST = 4 -> grant pattern LLLLF LLLLF; f_ready exactly on cycles 5 and 10.
- f_addr = 0x0000_1000 (OOR for ADDR_W = 10) -> mem_en = 0, f_ready = 1, next cycle f_rvalid = 1, f_rdata = 0x0000_0013. L write to the same address -> dropped, no memory write.
- Reset asserted in the cycle after an accepted F read -> f_rvalid = 0 the following cycle, streak = 0.
- With IMEM_ARB_PERF_EN, the both-requesting run above -> f_stall_cnt = 8, and l_wr_cnt counts only the accepted in-range writes.
